// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and, later, the read-side scheduler.
package fifo_arb_pkg;

    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_BURST_LEN  = 4;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

    // Index of the set bit in a one-hot vector; an all-zero vector maps to 0.
    function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first requester found after 'last', wrapping around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    pick,
    output logic               any_req
);

    int unsigned       idx;
    logic [ID_W-1:0]   cand;
    logic              found;

    // The search starts one past 'last', so the previous winner is considered last.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx  = (32'(last) + unsigned'(i)) % unsigned'(NUM_REQ);
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursting up to BURST_LEN beats per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = DEFAULT_BURST_LEN,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic                          fifo_full_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [ID_W-1:0]               gnt_id_o,
    output logic                          busy_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_e        state;
    logic [ID_W-1:0]   last;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ID_W-1:0]   pick;
    logic              any_req;
    logic              granted_req;
    logic              beat;
    logic              last_beat;
    logic              release_gnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req_i),
        .last    (last),
        .pick    (pick),
        .any_req (any_req)
    );

    assign granted_req  = |(req_i & gnt_o);
    assign beat         = granted_req & ~fifo_full_i & rst_n;
    assign last_beat    = beat && (beat_cnt == CNT_W'(BURST_LEN - 1));
    assign release_gnt  = ~granted_req | last_beat;

    assign fifo_wr_en_o = beat;
    assign busy_o       = (state == BURST);
    assign gnt_id_o     = ID_W'(onehot_to_idx(32'(gnt_o)));

    always_comb begin
        fifo_wdata_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k]) begin
                fifo_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // 'last' always equals the current grant holder, so a release re-arbitrates from it directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_o    <= '0;
            last     <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_o    <= NUM_REQ'(1) << pick;
                        last     <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (release_gnt) begin
                        beat_cnt <= '0;
                        if (any_req) begin
                            gnt_o <= NUM_REQ'(1) << pick;
                            last  <= pick;
                        end else begin
                            gnt_o <= '0;
                            state <= IDLE;
                        end
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: instance A uses BURST_LEN=4, instance B uses BURST_LEN=1.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        fifo_full;

    logic [3:0]  req_a;
    logic [31:0] wdata_a;
    logic [3:0]  gnt_a;
    logic [1:0]  gnt_id_a;
    logic        busy_a;
    logic        wr_en_a;
    logic [7:0]  wdata_o_a;

    logic [3:0]  req_b;
    logic [31:0] wdata_b;
    logic [3:0]  gnt_b;
    logic [1:0]  gnt_id_b;
    logic        busy_b;
    logic        wr_en_b;
    logic [7:0]  wdata_o_b;

    int checks;
    int errors;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .BURST_LEN  (4)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_a),
        .wdata_i      (wdata_a),
        .fifo_full_i  (fifo_full),
        .gnt_o        (gnt_a),
        .gnt_id_o     (gnt_id_a),
        .busy_o       (busy_a),
        .fifo_wr_en_o (wr_en_a),
        .fifo_wdata_o (wdata_o_a)
    );

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .BURST_LEN  (1)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_b),
        .wdata_i      (wdata_b),
        .fifo_full_i  (1'b0),
        .gnt_o        (gnt_b),
        .gnt_id_o     (gnt_id_b),
        .busy_o       (busy_b),
        .fifo_wr_en_o (wr_en_b),
        .fifo_wdata_o (wdata_o_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Leaves both instances freshly out of reset, at a falling edge, in IDLE.
    task automatic do_reset;
        @(negedge clk);
        rst_n     = 1'b0;
        req_a     = '0;
        req_b     = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        req_a = 4'b1111;
        req_b = 4'b1111;
        wdata_a = 32'h44332211;
        @(negedge clk);
        #1;
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt_a, 4'b0000); end
        checks++; if (gnt_id_a !== 2'd0) begin errors++; $display("[TB] FAIL reset_gnt_id: got %0d expected 0", gnt_id_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (wr_en_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en_a); end
        checks++; if (wdata_o_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 00", wdata_o_a); end
        checks++; if (gnt_b !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt_b: got %b expected %b", gnt_b, 4'b0000); end
        req_a = '0;
        req_b = '0;
    endtask

    task automatic test_single;
        do_reset();
        req_a   = 4'b0001;
        wdata_a = 32'h000000A5;
        #1;
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("[TB] FAIL single_latency_gnt: got %b expected %b", gnt_a, 4'b0000); end
        checks++; if (wr_en_a !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_wr_en: got %b expected 0", wr_en_a); end
        // Four beats of the first burst plus the first beat of the seamless re-grant.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++; if (gnt_a !== 4'b0001) begin errors++; $display("[TB] FAIL single_gnt cycle %0d: got %b expected %b", i, gnt_a, 4'b0001); end
            checks++; if (wr_en_a !== 1'b1) begin errors++; $display("[TB] FAIL single_wr_en cycle %0d: got %b expected 1", i, wr_en_a); end
            checks++; if (wdata_o_a !== 8'hA5) begin errors++; $display("[TB] FAIL single_wdata cycle %0d: got %h expected a5", i, wdata_o_a); end
            checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL single_busy cycle %0d: got %b expected 1", i, busy_a); end
        end
        @(negedge clk);
        req_a = '0;
        #1;
        checks++; if (wr_en_a !== 1'b0) begin errors++; $display("[TB] FAIL single_drop_wr_en: got %b expected 0", wr_en_a); end
        @(negedge clk);
        #1;
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("[TB] FAIL single_idle_gnt: got %b expected %b", gnt_a, 4'b0000); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b expected 0", busy_a); end
    endtask

    task automatic test_round_robin;
        int          writes;
        logic [1:0]  exp_id;
        logic [7:0]  exp_data;
        writes = 0;
        do_reset();
        req_a   = 4'b1111;
        wdata_a = 32'h13121110;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            exp_id   = 2'((i / 4) % 4);
            exp_data = 8'h10 + 8'(exp_id);
            if (i < 16 && wr_en_a === 1'b1) writes++;
            checks++; if (gnt_id_a !== exp_id) begin errors++; $display("[TB] FAIL rr_gnt_id cycle %0d: got %0d expected %0d", i, gnt_id_a, exp_id); end
            checks++; if (gnt_a !== (4'b0001 << exp_id)) begin errors++; $display("[TB] FAIL rr_gnt cycle %0d: got %b expected %b", i, gnt_a, 4'b0001 << exp_id); end
            checks++; if (wdata_o_a !== exp_data) begin errors++; $display("[TB] FAIL rr_wdata cycle %0d: got %h expected %h", i, wdata_o_a, exp_data); end
        end
        checks++; if (writes != 16) begin errors++; $display("[TB] FAIL rr_write_count: got %0d expected 16", writes); end
        req_a = '0;
    endtask

    task automatic test_full_stall;
        do_reset();
        req_a   = 4'b1010;
        wdata_a = 32'h33001100;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++; if (gnt_a !== 4'b0010) begin errors++; $display("[TB] FAIL stall_pre_gnt beat %0d: got %b expected %b", i, gnt_a, 4'b0010); end
            checks++; if (wr_en_a !== 1'b1) begin errors++; $display("[TB] FAIL stall_pre_wr_en beat %0d: got %b expected 1", i, wr_en_a); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fifo_full = 1'b1;
            #1;
            checks++; if (wr_en_a !== 1'b0) begin errors++; $display("[TB] FAIL stall_wr_en cycle %0d: got %b expected 0", i, wr_en_a); end
            checks++; if (gnt_a !== 4'b0010) begin errors++; $display("[TB] FAIL stall_gnt cycle %0d: got %b expected %b", i, gnt_a, 4'b0010); end
        end
        // Exactly two beats remain, proving the count held through the stall.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            fifo_full = 1'b0;
            #1;
            checks++; if (gnt_a !== 4'b0010) begin errors++; $display("[TB] FAIL stall_post_gnt beat %0d: got %b expected %b", i, gnt_a, 4'b0010); end
            checks++; if (wr_en_a !== 1'b1) begin errors++; $display("[TB] FAIL stall_post_wr_en beat %0d: got %b expected 1", i, wr_en_a); end
            checks++; if (wdata_o_a !== 8'h11) begin errors++; $display("[TB] FAIL stall_post_wdata beat %0d: got %h expected 11", i, wdata_o_a); end
        end
        @(negedge clk);
        #1;
        checks++; if (gnt_a !== 4'b1000) begin errors++; $display("[TB] FAIL stall_next_gnt: got %b expected %b", gnt_a, 4'b1000); end
        checks++; if (wdata_o_a !== 8'h33) begin errors++; $display("[TB] FAIL stall_next_wdata: got %h expected 33", wdata_o_a); end
        req_a = '0;
    endtask

    task automatic test_early_release;
        int writes2;
        writes2 = 0;
        do_reset();
        req_a   = 4'b0100;
        wdata_a = 32'h44220000;
        #1;
        @(negedge clk);
        #1;
        if (wr_en_a === 1'b1 && gnt_id_a === 2'd2) writes2++;
        checks++; if (gnt_a !== 4'b0100) begin errors++; $display("[TB] FAIL early_gnt: got %b expected %b", gnt_a, 4'b0100); end
        checks++; if (wdata_o_a !== 8'h22) begin errors++; $display("[TB] FAIL early_wdata: got %h expected 22", wdata_o_a); end
        @(negedge clk);
        req_a = 4'b1000;
        #1;
        if (wr_en_a === 1'b1 && gnt_id_a === 2'd2) writes2++;
        checks++; if (wr_en_a !== 1'b0) begin errors++; $display("[TB] FAIL early_drop_wr_en: got %b expected 0", wr_en_a); end
        @(negedge clk);
        #1;
        if (wr_en_a === 1'b1 && gnt_id_a === 2'd2) writes2++;
        checks++; if (gnt_a !== 4'b1000) begin errors++; $display("[TB] FAIL early_next_gnt: got %b expected %b", gnt_a, 4'b1000); end
        checks++; if (wr_en_a !== 1'b1) begin errors++; $display("[TB] FAIL early_next_wr_en: got %b expected 1", wr_en_a); end
        checks++; if (wdata_o_a !== 8'h44) begin errors++; $display("[TB] FAIL early_next_wdata: got %h expected 44", wdata_o_a); end
        checks++; if (writes2 != 1) begin errors++; $display("[TB] FAIL early_req2_writes: got %0d expected 1", writes2); end
        req_a = '0;
    endtask

    task automatic test_burst_len_one;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
        do_reset();
        req_b   = 4'b0101;
        wdata_b = 32'h00C000B0;
        #1;
        checks++; if (gnt_b !== 4'b0000) begin errors++; $display("[TB] FAIL bl1_latency_gnt: got %b expected %b", gnt_b, 4'b0000); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            exp_id   = (i % 2 == 0) ? 2'd0 : 2'd2;
            exp_data = (i % 2 == 0) ? 8'hB0 : 8'hC0;
            checks++; if (gnt_id_b !== exp_id) begin errors++; $display("[TB] FAIL bl1_gnt_id cycle %0d: got %0d expected %0d", i, gnt_id_b, exp_id); end
            checks++; if (wr_en_b !== 1'b1) begin errors++; $display("[TB] FAIL bl1_wr_en cycle %0d: got %b expected 1", i, wr_en_b); end
            checks++; if (wdata_o_b !== exp_data) begin errors++; $display("[TB] FAIL bl1_wdata cycle %0d: got %h expected %h", i, wdata_o_b, exp_data); end
        end
        req_b = '0;
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        req_a   = 4'b0001;
        wdata_a = 32'h0000005A;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++; if (wr_en_a !== 1'b1) begin errors++; $display("[TB] FAIL midrst_beat_wr_en beat %0d: got %b expected 1", i, wr_en_a); end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (wr_en_a !== 1'b0) begin errors++; $display("[TB] FAIL midrst_gated_wr_en: got %b expected 0", wr_en_a); end
        @(negedge clk);
        rst_n = 1'b1;
        req_a = 4'b1001;
        #1;
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_after_gnt: got %b expected %b", gnt_a, 4'b0000); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after_busy: got %b expected 0", busy_a); end
        @(negedge clk);
        #1;
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_regrant: got %b expected %b", gnt_a, 4'b0001); end
        checks++; if (gnt_id_a !== 2'd0) begin errors++; $display("[TB] FAIL midrst_regrant_id: got %0d expected 0", gnt_id_a); end
        req_a = '0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        req_a     = '0;
        req_b     = '0;
        wdata_a   = '0;
        wdata_b   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_burst_len_one();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
